// File: rtl/vmd_pkg.sv
// Shared constants and helpers for the motion-detector pixel pipeline.
package vmd_pkg;

  localparam int X_W        = 11;
  localparam int Y_W        = 10;
  localparam int LUMA_W     = 8;
  localparam int DEF_ADDR_W = 21;
  localparam int DEF_PIX_W  = 24;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  // Integer luma: (77R + 150G + 29B) >> 8, 16-bit sum, truncated.
  // The coefficients sum to 256, so the sum never exceeds 16 bits.
  function automatic logic [LUMA_W-1:0] luma(input logic [23:0] rgb);
    logic [15:0] sum;
    sum = ({8'd0, COEF_R} * {8'd0, rgb[23:16]})
        + ({8'd0, COEF_G} * {8'd0, rgb[15:8]})
        + ({8'd0, COEF_B} * {8'd0, rgb[7:0]});
    return sum[15:8];
  endfunction

endpackage

// File: rtl/frame_manager_rgb2gray.sv
// Registered RGB-to-luma converter: one pipeline stage.
module rgb2gray
  import vmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       rgb,
  output logic [LUMA_W-1:0] gray
);

  // Convert the incoming pixel and register the luma sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gray <= '0;
    else     gray <= luma(rgb);
  end

endmodule

// File: rtl/frame_manager.sv
// Front-end pixel stage: luma conversion, frame position tracking,
// buffer addressing with ping-pong select, and frame-boundary checks.
module frame_manager
  import vmd_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [X_W-1:0]    cfg_width,
  input  logic [Y_W-1:0]    cfg_height,
  input  logic [PIX_W-1:0]  s_pixel,
  input  logic              s_last,
  output logic [LUMA_W-1:0] gray,
  output logic              gray_valid,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              sof,
  output logic              eof,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_sel,
  output logic [1:0]        frame_idx,
  output logic              err_last_early,
  output logic              err_last_missing
);

  // Position state and latched geometry
  logic [X_W-1:0]    x_cnt, w_lat, w_cur;
  logic [Y_W-1:0]    y_cnt, h_lat, h_cur;
  logic [ADDR_W-1:0] addr_cnt;
  logic              at_start, geom_zero, last_x, last_pos, frame_end;

  // Stage 1 registers
  logic              s1_valid, s1_sof, s1_eof, s1_ee, s1_em;
  logic [PIX_W-1:0]  s1_rgb;
  logic [X_W-1:0]    s1_x;
  logic [Y_W-1:0]    s1_y;
  logic [ADDR_W-1:0] s1_addr;

  // Geometry in force for this pixel and boundary decode.
  always_comb begin
    at_start  = (x_cnt == '0) && (y_cnt == '0);
    w_cur     = at_start ? cfg_width  : w_lat;
    h_cur     = at_start ? cfg_height : h_lat;
    geom_zero = (w_cur == 11'd0) || (h_cur == 10'd0);
    last_x    = (x_cnt == w_cur - 11'd1);
    last_pos  = last_x && (y_cnt == h_cur - 10'd1);
    frame_end = s_last || last_pos;
  end

  // Advance position, address and geometry latch on accepted pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      addr_cnt <= '0;
      w_lat    <= '0;
      h_lat    <= '0;
    end else if (enb) begin
      if (at_start) begin
        w_lat <= cfg_width;
        h_lat <= cfg_height;
      end
      if (geom_zero || frame_end) begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        addr_cnt <= '0;
      end else if (last_x) begin
        x_cnt    <= '0;
        y_cnt    <= y_cnt + 10'd1;
        addr_cnt <= addr_cnt + 21'(1);
      end else begin
        x_cnt    <= x_cnt + 11'd1;
        addr_cnt <= addr_cnt + 21'(1);
      end
    end
  end

  // Stage 1: capture pixel, position, address and boundary flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_ee    <= 1'b0;
      s1_em    <= 1'b0;
      s1_rgb   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= enb && !geom_zero;
      s1_sof   <= enb && !geom_zero && at_start;
      s1_eof   <= enb && !geom_zero && frame_end;
      s1_ee    <= enb && !geom_zero && s_last && !last_pos;
      s1_em    <= enb && (geom_zero || (last_pos && !s_last));
      if (enb) begin
        s1_rgb  <= s_pixel;
        s1_x    <= x_cnt;
        s1_y    <= y_cnt;
        s1_addr <= addr_cnt;
      end
    end
  end

  // Stage 2 luma conversion runs in parallel with the forwarding below.
  rgb2gray u_rgb2gray (
    .clk  (clk),
    .rst  (rst),
    .rgb  (s1_rgb[23:0]),
    .gray (gray)
  );

  // Stage 2: forward aligned side-band; flip buffer and count frames after eof.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_valid       <= 1'b0;
      pix_x            <= '0;
      pix_y            <= '0;
      sof              <= 1'b0;
      eof              <= 1'b0;
      buf_addr         <= '0;
      buf_sel          <= 1'b0;
      frame_idx        <= 2'd0;
      err_last_early   <= 1'b0;
      err_last_missing <= 1'b0;
    end else begin
      gray_valid       <= s1_valid;
      pix_x            <= s1_x;
      pix_y            <= s1_y;
      sof              <= s1_sof;
      eof              <= s1_eof;
      buf_addr         <= s1_addr;
      err_last_early   <= s1_ee;
      err_last_missing <= s1_em;
      if (gray_valid && eof) begin
        buf_sel <= ~buf_sel;
        if (frame_idx != 2'd3) frame_idx <= frame_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_manager.sv
module tb_frame_manager;
  import vmd_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enb = 1'b0;
  logic [10:0]       cfg_width = 11'd0;
  logic [9:0]        cfg_height = 10'd0;
  logic [23:0]       s_pixel = 24'd0;
  logic              s_last = 1'b0;
  logic [7:0]        gray;
  logic              gray_valid, sof, eof, buf_sel, err_last_early, err_last_missing;
  logic [10:0]       pix_x;
  logic [9:0]        pix_y;
  logic [20:0]       buf_addr;
  logic [1:0]        frame_idx;

  int n_chk = 0;
  int n_fail = 0;

  frame_manager dut (
    .clk(clk), .rst(rst), .enb(enb), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_pixel(s_pixel), .s_last(s_last), .gray(gray), .gray_valid(gray_valid),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eof(eof), .buf_addr(buf_addr),
    .buf_sel(buf_sel), .frame_idx(frame_idx), .err_last_early(err_last_early),
    .err_last_missing(err_last_missing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [23:0] rgb;
    logic        last;
    logic [10:0] w;
    logic [9:0]  h;
    logic        v;
    logic [7:0]  g;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof;
    logic        eof;
    logic [20:0] addr;
    logic        bs;
    logic [1:0]  fi;
    logic        ee;
    logic        em;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int en, int rgb, int last, int w, int h, int v, int g,
                              int x, int y, int sf, int ef, int addr, int bs, int fi,
                              int ee, int em);
    vec_t r;
    r.en = 1'(en); r.rgb = 24'(rgb); r.last = 1'(last); r.w = 11'(w); r.h = 10'(h);
    r.v = 1'(v); r.g = 8'(g); r.x = 11'(x); r.y = 10'(y); r.sof = 1'(sf);
    r.eof = 1'(ef); r.addr = 21'(addr); r.bs = 1'(bs); r.fi = 2'(fi);
    r.ee = 1'(ee); r.em = 1'(em);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(gray_valid), 32'd0);
    chk({tag, " gray"},  32'(gray),       32'd0);
    chk({tag, " x"},     32'(pix_x),      32'd0);
    chk({tag, " y"},     32'(pix_y),      32'd0);
    chk({tag, " addr"},  32'(buf_addr),   32'd0);
    chk({tag, " bsel"},  32'(buf_sel),    32'd0);
    chk({tag, " fidx"},  32'(frame_idx),  32'd0);
    chk({tag, " flags"}, 32'({sof, eof, err_last_early, err_last_missing}), 32'd0);
  endtask

  initial begin
    // en rgb last w h | v gray x y sof eof addr bs fi ee em
    // Frame 1: nominal 4x2, s_last on pixel 8
    vq.push_back(mk(1, 'hFF0000, 0, 4, 2, 1,  76, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 'h00FF00, 0, 4, 2, 1, 149, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 'h0000FF, 0, 4, 2, 1,  28, 2, 0, 0, 0, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 'hFFFFFF, 0, 4, 2, 1, 255, 3, 0, 0, 0, 3, 0, 0, 0, 0));
    vq.push_back(mk(1, 'h808080, 0, 4, 2, 1, 128, 0, 1, 0, 0, 4, 0, 0, 0, 0));
    vq.push_back(mk(1, 'h000000, 0, 4, 2, 1,   0, 1, 1, 0, 0, 5, 0, 0, 0, 0));
    vq.push_back(mk(1, 'hFF0000, 0, 4, 2, 1,  76, 2, 1, 0, 0, 6, 0, 0, 0, 0));
    vq.push_back(mk(1, 'hFFFFFF, 1, 4, 2, 1, 255, 3, 1, 0, 1, 7, 0, 0, 0, 0));
    // Frame 2: early s_last on pixel 5
    vq.push_back(mk(1, 'h00FF00, 0, 4, 2, 1, 149, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(1, 'h0000FF, 0, 4, 2, 1,  28, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 'h808080, 0, 4, 2, 1, 128, 2, 0, 0, 0, 2, 1, 1, 0, 0));
    vq.push_back(mk(1, 'hFF0000, 0, 4, 2, 1,  76, 3, 0, 0, 0, 3, 1, 1, 0, 0));
    vq.push_back(mk(1, 'hFFFFFF, 1, 4, 2, 1, 255, 0, 1, 0, 1, 4, 1, 1, 1, 0));
    // Frame 3: no s_last, width changed to 2 mid-frame (ignored)
    vq.push_back(mk(1, 'h0000FF, 0, 4, 2, 1,  28, 0, 0, 1, 0, 0, 0, 2, 0, 0));
    vq.push_back(mk(1, 'hFF0000, 0, 4, 2, 1,  76, 1, 0, 0, 0, 1, 0, 2, 0, 0));
    vq.push_back(mk(1, 'h00FF00, 0, 4, 2, 1, 149, 2, 0, 0, 0, 2, 0, 2, 0, 0));
    vq.push_back(mk(1, 'h808080, 0, 2, 2, 1, 128, 3, 0, 0, 0, 3, 0, 2, 0, 0));
    vq.push_back(mk(1, 'hFFFFFF, 0, 2, 2, 1, 255, 0, 1, 0, 0, 4, 0, 2, 0, 0));
    vq.push_back(mk(1, 'h000000, 0, 2, 2, 1,   0, 1, 1, 0, 0, 5, 0, 2, 0, 0));
    vq.push_back(mk(1, 'h0000FF, 0, 2, 2, 1,  28, 2, 1, 0, 0, 6, 0, 2, 0, 0));
    vq.push_back(mk(1, 'h00FF00, 0, 2, 2, 1, 149, 3, 1, 0, 1, 7, 0, 2, 0, 1));
    // Frame 4: W=2 now in force, enb gaps
    vq.push_back(mk(1, 'h808080, 0, 2, 2, 1, 128, 0, 0, 1, 0, 0, 1, 3, 0, 0));
    vq.push_back(mk(0, 'h123456, 0, 2, 2, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 'hFF0000, 0, 2, 2, 1,  76, 1, 0, 0, 0, 1, 1, 3, 0, 0));
    vq.push_back(mk(0, 'h654321, 1, 2, 2, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 'hABCDEF, 0, 2, 2, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 'hFFFFFF, 0, 2, 2, 1, 255, 0, 1, 0, 0, 2, 1, 3, 0, 0));
    vq.push_back(mk(1, 'h0000FF, 1, 2, 2, 1,  28, 1, 1, 0, 1, 3, 1, 3, 0, 0));
    // Frame 5: frame_idx stays saturated at 3
    vq.push_back(mk(1, 'h00FF00, 0, 2, 2, 1, 149, 0, 0, 1, 0, 0, 0, 3, 0, 0));
    vq.push_back(mk(0, 'h000000, 0, 2, 2, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 'h000000, 0, 2, 2, 1,   0, 1, 0, 0, 0, 1, 0, 3, 0, 0));

    // Reset state
    #1;
    chk_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: vector i driven at negedge i, its output sampled at negedge i+2
    for (int i = 0; i < vq.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vec_t e;
        string t;
        e = vq[i-2];
        t = $sformatf("v%0d", i - 2);
        chk({t, " valid"}, 32'(gray_valid), 32'(e.v));
        chk({t, " em"},    32'(err_last_missing), 32'(e.em));
        chk({t, " ee"},    32'(err_last_early), 32'(e.ee));
        if (e.v) begin
          chk({t, " gray"}, 32'(gray),      32'(e.g));
          chk({t, " x"},    32'(pix_x),     32'(e.x));
          chk({t, " y"},    32'(pix_y),     32'(e.y));
          chk({t, " sof"},  32'(sof),       32'(e.sof));
          chk({t, " eof"},  32'(eof),       32'(e.eof));
          chk({t, " addr"}, 32'(buf_addr),  32'(e.addr));
          chk({t, " bsel"}, 32'(buf_sel),   32'(e.bs));
          chk({t, " fidx"}, 32'(frame_idx), 32'(e.fi));
        end else begin
          chk({t, " eof"}, 32'(eof), 32'd0);
        end
      end
      if (i < vq.size()) begin
        enb        = vq[i].en;
        s_pixel    = vq[i].rgb;
        s_last     = vq[i].last;
        cfg_width  = vq[i].w;
        cfg_height = vq[i].h;
      end else begin
        enb    = 1'b0;
        s_last = 1'b0;
      end
    end

    // Mid-frame reset with a pixel in flight
    @(negedge clk);
    enb = 1'b1; s_pixel = 24'hFFFFFF; s_last = 1'b0;
    @(negedge clk);
    enb = 1'b0;
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst valid", 32'(gray_valid), 32'd0);

    // Zero-width geometry: pixel dropped, missing-last pulse
    enb = 1'b1; cfg_width = 11'd0; cfg_height = 10'd2; s_pixel = 24'hFFFFFF;
    @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    chk("drop valid", 32'(gray_valid), 32'd0);
    chk("drop em",    32'(err_last_missing), 32'd1);
    chk("drop eof",   32'(eof), 32'd0);
    // Next frame after the drop and reset starts at (0,0)
    enb = 1'b1; cfg_width = 11'd3; cfg_height = 10'd1; s_pixel = 24'h00FF00;
    @(negedge clk);
    enb = 1'b0;
    chk("drop pulse width", 32'(err_last_missing), 32'd0);
    @(negedge clk);
    chk("restart valid", 32'(gray_valid), 32'd1);
    chk("restart gray",  32'(gray), 32'd149);
    chk("restart x",     32'(pix_x), 32'd0);
    chk("restart y",     32'(pix_y), 32'd0);
    chk("restart sof",   32'(sof), 32'd1);
    chk("restart addr",  32'(buf_addr), 32'd0);
    chk("restart fidx",  32'(frame_idx), 32'd0);
    chk("restart bsel",  32'(buf_sel), 32'd0);
    @(negedge clk);
    chk("single output", 32'(gray_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_manager.md
# frame_manager

Front-end pixel stage of the motion-detector pipeline, enabled by the control unit's `frame_manager_enb`. Each accepted RGB pixel becomes an 8-bit luma sample. The block tracks its (x, y) position against the latched frame geometry and produces frame-buffer addresses with a ping-pong buffer select. It also flags malformed frame boundaries. Its outputs feed the sigma-delta, motion-detector and memory-manager stages.

## Interface
- `PIX_W`, 24: RGB pixel width, {R[23:16], G[15:8], B[7:0]}
- `ADDR_W`, 21: frame-buffer address width; 2^21 ≥ 2047×1023
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `enb`  in  1  pixel accept strobe (`frame_manager_enb`)
- `cfg_width`  in  11  frame width in pixels
- `cfg_height`  in  10  frame height in lines
- `s_pixel`  in  PIX_W  RGB pixel, sampled when `enb`=1
- `s_last`  in  1  end-of-frame marker, sampled when `enb`=1
- `gray`  out  8  luma sample
- `gray_valid`  out  1  `gray` and all aligned outputs valid
- `pix_x`  out  11  column of the current `gray` sample
- `pix_y`  out  10  line of the current `gray` sample
- `sof`  out  1  sample is (0,0)
- `eof`  out  1  sample ends a frame, by `s_last` or by counter wrap
- `buf_addr`  out  ADDR_W  linear address y×W+x
- `buf_sel`  out  1  ping-pong buffer of the current frame
- `frame_idx`  out  2  completed-frame count, saturates at 3
- `err_last_early`  out  1  pulse: `s_last` arrived before (W-1, H-1)
- `err_last_missing`  out  1  pulse: (W-1, H-1) reached without `s_last`

## Operation
- Geometry latch: `cfg_width`/`cfg_height` are captured into W/H on the first `enb` cycle of each frame, i.e. when the counter is at (0,0). Mid-frame config changes are ignored until the next frame.
- If the latched W=0 or H=0, pixels are dropped: no `gray_valid`, counters held at 0, and `err_last_missing` pulses on every `enb` cycle.
- Luma: `gray` = (77·R + 150·G + 29·B) >> 8. The sum is 16-bit unsigned, truncated, with no rounding. White (FFFFFF) → 255, black → 0.
- Counters advance only on `enb`:
  - x increments.
  - At x=W-1, x wraps to 0 and y increments.
  - At (W-1, H-1), both wrap to (0,0).
- Address: a running register, reset to 0 at frame start and incremented per accepted pixel. No multiplier.
- Frame end (wrap or `s_last`) does all of the following:
  - asserts `eof`
  - toggles `buf_sel`
  - increments `frame_idx` (saturating)
  - returns the counters to (0,0)
- `s_last` at (W-1, H-1): normal end, no error.
- `s_last` before (W-1, H-1): frame is terminated early and `err_last_early` pulses with `eof`.
- Reaching (W-1, H-1) without `s_last`: frame wraps and `err_last_missing` pulses with `eof`.
- `enb`=0: the pipeline freezes its counters. In-flight samples still drain, so `gray_valid` reflects only accepted pixels.

## Timing
- Latency: 2 cycles from an `enb`-sampled pixel to `gray_valid`.
  - Stage 1 registers RGB, position, address and flags.
  - Stage 2 registers luma and forwards the rest.
- Alignment: `pix_x`, `pix_y`, `sof`, `eof`, `buf_addr`, `buf_sel`, error pulses and `gray` all refer to the same pixel in the `gray_valid` cycle.
- `buf_sel`/`frame_idx` update visibly one cycle after the `eof` output cycle.
- Back-to-back `enb`: one output per cycle, no bubbles.
- Reset: all outputs, counters, W/H, `buf_sel` and `frame_idx` go to 0 asynchronously. A reset mid-frame discards in-flight pixels, and the next `enb` starts a new frame at (0,0).
- Error pulses: one cycle wide, never held.

## Structure
- Shared package `vmd_pkg`:
  - width constants: `X_W`=11, `Y_W`=10, `LUMA_W`=8
  - luma coefficients: 77, 150, 29
  - `ADDR_W` default
- One sub-module, `rgb2gray`: a registered luma converter (one pipeline stage), reusable by the overlay stage.
- Position, address and frame bookkeeping stay in `frame_manager`.

## Test plan
- Nominal frame: W=4, H=2, 8 pixels with `enb` continuous and `s_last` on the 8th.
  - Expect `gray_valid` 2 cycles after each pixel.
  - Expect (x, y) sequence (0,0)…(3,1) and `buf_addr` 0…7.
  - Expect `sof` on pixel 1 and `eof` on pixel 8, with no errors.
  - Expect `buf_sel` = 1 and `frame_idx` = 1 afterwards.
- Luma values:
  - FF0000 → 76
  - 00FF00 → 149
  - 0000FF → 28
  - FFFFFF → 255
  - 808080 → 128
- Early `s_last`: W=4, H=2, `s_last` on pixel 5.
  - Expect `eof` and `err_last_early` on pixel 5, `buf_sel` toggled.
  - Expect the next pixel at (0,0) with `sof`.
- Missing `s_last` plus config change: 8 pixels with no `s_last` and `cfg_width` changed to 2 mid-frame.
  - Expect the wrap at (3,1) with `err_last_missing`.
  - Expect the next frame to use W=2.
- Gaps and reset: random `enb` gaps over 3 frames.
  - Expect counters and addresses contiguous, and `frame_idx` saturating at 3 after the 4th frame.
  - Assert `rst` mid-frame: all outputs go to 0 and the next pixel is (0,0).
